// File: rtl/frame_pkg.sv
// Constants and state encoding shared by the frame builder, the aligner and the scoreboard.
package frame_pkg;

  localparam logic [7:0] HEAD1_LO = 8'hAA;
  localparam logic [7:0] HEAD1_HI = 8'hAF;
  localparam logic [7:0] HEAD2_LO = 8'h55;
  localparam logic [7:0] HEAD2_HI = 8'hBA;

  localparam int PAYLOAD_LEN = 10;
  localparam int FRAME_LEN   = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR_LO  = 2'd1,
    HDR_HI  = 2'd2,
    PAYLOAD = 2'd3
  } frame_state_e;

  function automatic logic [7:0] hdr_lo_byte(input logic sel);
    return sel ? HEAD2_LO : HEAD1_LO;
  endfunction

  // A corrupted header keeps the valid low byte so the aligner sees a near-miss.
  function automatic logic [7:0] hdr_hi_byte(input logic sel, input logic corrupt);
    if (corrupt) begin
      return 8'h00;
    end
    return sel ? HEAD2_HI : HEAD1_HI;
  endfunction

endpackage

// File: rtl/frame_tx_fifo.sv
// Payload buffer for the frame builder: synchronous FIFO with a registered
// occupancy count and a registered ready flag (low while in reset).
module frame_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_data_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [7:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ready_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Tracks the registered count, so a pop never frees a slot in its own cycle.
    ready_d = (count_d < DEPTH_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign ready_o   = ready_q;

endmodule

// File: rtl/frame_builder.sv
// Byte-stream framer: wraps every 10 buffered payload bytes in a 2-byte header
// and drives one byte per clock toward the aligner.
//   state   | meaning
//   IDLE    | idle byte on the lane, waiting for a full payload
//   HDR_LO  | header low byte on the lane
//   HDR_HI  | header high byte (or 00 if corrupted) on the lane
//   PAYLOAD | payload byte tx_byte_pos-2 on the lane
module frame_builder
  import frame_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       hdr_sel,
  input  logic       corrupt_hdr,
  output logic [7:0] tx_data,
  output logic [3:0] tx_byte_pos,
  output logic       tx_in_frame,
  output logic       fr_start
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(PAYLOAD_LEN);
  localparam logic [3:0]       LAST_POS  = 4'(FRAME_LEN - 1);

  frame_state_e     state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [3:0]       pos_q, pos_d;
  logic             in_frame_q, in_frame_d;
  logic             fr_start_q, fr_start_d;
  logic             sel_q, corrupt_q;
  logic             begin_frame;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_ready;
  logic             payload_ready;

  frame_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_data_i (s_data),
    .push_i    (s_valid),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .ready_o   (fifo_ready)
  );

  assign payload_ready = (fifo_count >= START_CNT);

  // Outputs are computed for the next cycle and registered, so a start
  // decision taken this cycle puts the header low byte on the lane next cycle.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = IDLE_BYTE;
    pos_d       = '0;
    in_frame_d  = 1'b0;
    fr_start_d  = 1'b0;
    fifo_pop    = 1'b0;
    begin_frame = 1'b0;

    unique case (state_q)
      IDLE: begin
        begin_frame = payload_ready;
      end
      HDR_LO: begin
        state_d    = HDR_HI;
        tx_data_d  = hdr_hi_byte(sel_q, corrupt_q);
        pos_d      = 4'd1;
        in_frame_d = 1'b1;
      end
      HDR_HI: begin
        state_d    = PAYLOAD;
        tx_data_d  = fifo_head;
        pos_d      = 4'd2;
        in_frame_d = 1'b1;
        fifo_pop   = 1'b1;
      end
      PAYLOAD: begin
        if (pos_q == LAST_POS) begin
          state_d     = IDLE;
          begin_frame = payload_ready;
        end else begin
          tx_data_d  = fifo_head;
          pos_d      = pos_q + 4'd1;
          in_frame_d = 1'b1;
          fifo_pop   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (begin_frame) begin
      state_d    = HDR_LO;
      tx_data_d  = hdr_lo_byte(hdr_sel);
      pos_d      = '0;
      in_frame_d = 1'b1;
      fr_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= IDLE_BYTE;
      pos_q      <= '0;
      in_frame_q <= 1'b0;
      fr_start_q <= 1'b0;
      sel_q      <= 1'b0;
      corrupt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      pos_q      <= pos_d;
      in_frame_q <= in_frame_d;
      fr_start_q <= fr_start_d;
      if (begin_frame) begin
        sel_q     <= hdr_sel;
        corrupt_q <= corrupt_hdr;
      end
    end
  end

  assign s_ready     = fifo_ready;
  assign tx_data     = tx_data_q;
  assign tx_byte_pos = pos_q;
  assign tx_in_frame = in_frame_q;
  assign fr_start    = fr_start_q;

endmodule

// File: tb/tb_frame_builder.sv
// Bench for frame_builder: queue-based reference model checked every cycle,
// a table of header variants, and directed multi-cycle sequences.
module tb_frame_builder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       hdr_sel = 1'b0;
  logic       corrupt_hdr = 1'b0;
  logic [7:0] tx_data;
  logic [3:0] tx_byte_pos;
  logic       tx_in_frame;
  logic       fr_start;

  always #5 clk = ~clk;

  frame_builder #(
    .FIFO_DEPTH(16),
    .IDLE_BYTE (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .hdr_sel     (hdr_sel),
    .corrupt_hdr (corrupt_hdr),
    .tx_data     (tx_data),
    .tx_byte_pos (tx_byte_pos),
    .tx_in_frame (tx_in_frame),
    .fr_start    (fr_start)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // m_q holds accepted bytes not yet committed to a frame; m_pend holds the
  // bytes of the frame in flight that have not reached the lane yet.
  typedef struct {
    logic [7:0] b;
    bit         pay;
    int         pos;
  } ent_t;

  logic [7:0] m_q[$];
  ent_t       m_pend[$];
  logic [7:0] e_tx  = 8'h00;
  int         e_pos = 0;
  bit         e_in  = 1'b0;
  bit         e_st  = 1'b0;
  bit         e_rdy = 1'b0;

  function automatic int pend_pay();
    int n = 0;
    foreach (m_pend[i]) if (m_pend[i].pay) n++;
    return n;
  endfunction

  always @(posedge clk) begin : model
    bit         acc;
    ent_t       e;
    logic [7:0] pb;
    acc = s_valid && e_rdy;
    if (reset) begin
      m_q.delete();
      m_pend.delete();
      e_tx = 8'h00; e_pos = 0; e_in = 1'b0; e_st = 1'b0; e_rdy = 1'b0;
    end else begin
      if (m_pend.size() == 0 && m_q.size() >= 10) begin
        e.b = hdr_sel ? 8'h55 : 8'hAA; e.pay = 1'b0; e.pos = 0;
        m_pend.push_back(e);
        e.b = corrupt_hdr ? 8'h00 : (hdr_sel ? 8'hBA : 8'hAF); e.pos = 1;
        m_pend.push_back(e);
        for (int i = 0; i < 10; i++) begin
          pb = m_q.pop_front();
          e.b = pb; e.pay = 1'b1; e.pos = i + 2;
          m_pend.push_back(e);
        end
      end
      if (m_pend.size() != 0) begin
        e = m_pend.pop_front();
        e_tx = e.b; e_pos = e.pos; e_in = 1'b1; e_st = (e.pos == 0);
      end else begin
        e_tx = 8'h00; e_pos = 0; e_in = 1'b0; e_st = 1'b0;
      end
      if (acc) m_q.push_back(s_data);
      e_rdy = (m_q.size() + pend_pay()) < 16;
    end
    #2;
    if (reset) begin
      check("m_rst_tx", tx_data, 8'h00);
      check("m_rst_pos", tx_byte_pos, 0);
      check("m_rst_in", tx_in_frame, 0);
      check("m_rst_st", fr_start, 0);
      check("m_rst_rdy", s_ready, 0);
    end else begin
      check("m_tx", tx_data, e_tx);
      check("m_pos", tx_byte_pos, e_pos);
      check("m_in", tx_in_frame, e_in);
      check("m_st", fr_start, e_st);
      check("m_rdy", s_ready, e_rdy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit ok;
      guard = 0;
      s_valid = 1'b1;
      s_data  = first + 8'(i);
      do begin
        ok = s_ready;
        step();
        guard++;
      end while (!ok && guard < 100);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL send_timeout: byte %0d not accepted in %0d cycles", i, guard);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!fr_start && lat < limit);
    if (!fr_start) begin
      tests++; fails++;
      $display("FAIL wait_start: got no fr_start, required one within %0d cycles", limit);
    end
  endtask

  typedef struct {
    logic       sel;
    logic       cor;
    logic [7:0] first;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    vecs[0] = '{1'b0, 1'b0, 8'h01, 8'hAA, 8'hAF};
    vecs[1] = '{1'b0, 1'b1, 8'h11, 8'hAA, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h21, 8'hAA, 8'hAF};
    vecs[3] = '{1'b1, 1'b0, 8'h31, 8'h55, 8'hBA};

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_data, 8'h00);
    check("rst_rdy", s_ready, 0);
    check("rst_in", tx_in_frame, 0);
    reset = 1'b0;
    step();
    check("post_rst_rdy", s_ready, 1);
    check("post_rst_tx", tx_data, 8'h00);
    repeat (5) begin
      step();
      check("idle_in", tx_in_frame, 0);
    end

    // header variants; hdr_sel/corrupt_hdr flipped right after frame start
    foreach (vecs[k]) begin
      hdr_sel = vecs[k].sel;
      corrupt_hdr = vecs[k].cor;
      send(10, vecs[k].first);
      wait_start(5, lat);
      check("tbl_lat", lat, 1);
      check("tbl_b0", tx_data, vecs[k].lo);
      check("tbl_pos0", tx_byte_pos, 0);
      hdr_sel = ~hdr_sel;
      corrupt_hdr = ~corrupt_hdr;
      step();
      check("tbl_b1", tx_data, vecs[k].hi);
      check("tbl_pos1", tx_byte_pos, 1);
      for (int i = 0; i < 10; i++) begin
        step();
        check("tbl_pay", tx_data, vecs[k].first + 8'(i));
        check("tbl_pos", tx_byte_pos, i + 2);
      end
      step();
      check("tbl_idle_tx", tx_data, 8'h00);
      check("tbl_idle_in", tx_in_frame, 0);
      hdr_sel = 1'b0;
      corrupt_hdr = 1'b0;
    end

    // nine bytes never start a frame; the tenth does
    send(9, 8'h40);
    repeat (15) begin
      step();
      check("nine_no_frame", tx_in_frame, 0);
    end
    send(1, 8'h49);
    step();
    check("tenth_start", fr_start, 1);
    check("tenth_hdr", tx_data, 8'hAA);
    repeat (12) step();

    // continuous 50 bytes: five back-to-back frames and FIFO-full backpressure
    hdr_sel = 1'b1;
    fork
      send(50, 8'h80);
      begin : collect
        int starts[$];
        int seen, t;
        logic [7:0] exp_b;
        bit full;
        seen = 0; t = 0; exp_b = 8'h80; full = 1'b0;
        while (seen < 50 && t < 400) begin
          step();
          t++;
          if (!s_ready) full = 1'b1;
          if (fr_start) begin
            starts.push_back(t);
            check("b2b_hdr_lo", tx_data, 8'h55);
          end
          if (tx_in_frame && tx_byte_pos == 4'd1) check("b2b_hdr_hi", tx_data, 8'hBA);
          if (tx_in_frame && tx_byte_pos >= 4'd2) begin
            check("b2b_pay", tx_data, exp_b);
            exp_b++;
            seen++;
          end
        end
        check("b2b_bytes", seen, 50);
        check("b2b_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) check("b2b_period", starts[i] - starts[i-1], 12);
        check("b2b_full_seen", full, 1);
      end
    join
    hdr_sel = 1'b0;
    repeat (3) step();

    // reset mid-frame at byte position 6
    send(10, 8'hC0);
    wait_start(5, lat);
    repeat (6) step();
    check("pre_rst_pos", tx_byte_pos, 6);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx_data, 8'h00);
    check("mid_rst_pos", tx_byte_pos, 0);
    check("mid_rst_in", tx_in_frame, 0);
    check("mid_rst_st", fr_start, 0);
    check("mid_rst_rdy", s_ready, 0);
    step();
    reset = 1'b0;
    send(9, 8'hD0);
    repeat (5) begin
      step();
      check("post_rst_empty", tx_in_frame, 0);
    end
    send(1, 8'hD9);
    wait_start(5, lat);
    check("clean_b0", tx_data, 8'hAA);
    step();
    check("clean_b1", tx_data, 8'hAF);
    for (int i = 0; i < 10; i++) begin
      step();
      check("clean_pay", tx_data, 8'hD0 + 8'(i));
    end
    repeat (3) step();

    // random traffic against the model
    repeat (800) begin
      s_valid     = ($urandom_range(0, 3) != 0);
      s_data      = 8'($urandom);
      hdr_sel     = 1'($urandom_range(0, 1));
      corrupt_hdr = ($urandom_range(0, 7) == 0);
      step();
    end
    s_valid = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
